gray_pixel_packer: RTL and testbench



---
 rtl/gray_pkg.sv | 27 ++
 rtl/gray_word_fifo.sv | 52 +++++
 rtl/gray_pixel_packer.sv | 113 +++++++++++
 tb/tb_gray_pixel_packer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared widths, FIFO entry layout and keep-mask helper
package gray_pkg;
  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  // FIFO entry is {last, keep, data}
  localparam int DATA_LSB = 0;
  localparam int KEEP_LSB = WORD_W;
  localparam int LAST_BIT = WORD_W + LANES;
  localparam int ENTRY_W  = WORD_W + LANES + 1;

  typedef struct packed {
    logic              last;
    logic [LANES-1:0]  keep;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  function automatic logic [LANES-1:0] keep_mask(input logic [2:0] filled);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(filled)) m[i] = 1'b1;
    end
    return m;
  endfunction
endpackage

// File: rtl/gray_word_fifo.sv
// rtl/gray_word_fifo.sv - synchronous FIFO with registered count
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module gray_word_fifo
  import gray_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end
endmodule

// File: rtl/gray_pixel_packer.sv
// rtl/gray_pixel_packer.sv - rounds/saturates gray values to bytes and packs four per word
// The converter upstream cannot stall, so words that find the FIFO full are dropped and flagged.
module gray_pixel_packer
  import gray_pkg::*;
#(
  parameter int FRAC_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] gray_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last,
  output logic        overflow
);
  localparam logic [32:0] HALF = 33'd1 << (FRAC_BITS - 1);

  logic [32:0]        rounded;
  logic [32:0]        scaled;
  logic [PIX_W-1:0]   pix_sat;

  logic               s1_valid;
  logic [PIX_W-1:0]   s1_pix;
  logic               flush_q;

  logic [1:0]         lane;
  logic [WORD_W-1:0]  pack;
  logic [WORD_W-1:0]  pack_next;
  logic [2:0]         filled;
  logic               push;
  fifo_entry_t        entry;

  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  // 33-bit sum keeps the rounding carry of a near-max input
  always_comb begin
    rounded = {1'b0, gray_in} + HALF;
    scaled  = rounded >> FRAC_BITS;
    pix_sat = (scaled > 33'd255) ? 8'hFF : scaled[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      flush_q  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_pix   <= pix_sat;
      flush_q  <= flush;
    end
  end

  always_comb begin
    pack_next = pack;
    if (s1_valid) pack_next[lane*PIX_W +: PIX_W] = s1_pix;
    filled     = {1'b0, lane} + {2'b00, s1_valid};
    push       = (s1_valid && (lane == 2'd3)) || (flush_q && (filled != 3'd0));
    entry.data = pack_next;
    entry.keep = keep_mask(filled);
    entry.last = flush_q;
  end

  // A push restarts packing even when the word was dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      lane <= '0;
      pack <= '0;
    end else if (push) begin
      lane <= '0;
      pack <= '0;
    end else if (s1_valid) begin
      lane <= lane + 1'b1;
      pack <= pack_next;
    end
  end

  gray_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? head[DATA_LSB +: WORD_W] : '0;
  assign out_keep  = out_valid ? head[KEEP_LSB +: LANES]  : '0;
  assign out_last  = out_valid ? head[LAST_BIT]           : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gray_pixel_packer.sv
// tb/tb_gray_pixel_packer.sv - directed tests checked against a queue-based reference model
module tb_gray_pixel_packer;
  localparam int FRAC  = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] gray_in = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  gray_pixel_packer #(.FRAC_BITS(FRAC), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t       mq[$];
  int unsigned pend[$];
  bit          m_s1v;
  bit          m_s1f;
  int unsigned m_s1p;
  bit          m_ovf;

  function automatic int unsigned quant(input logic [31:0] g);
    longint unsigned v;
    v = ({32'd0, g} + (64'd1 << (FRAC - 1))) / (64'd1 << FRAC);
    return (v > 255) ? 255 : int'(v);
  endfunction

  always @(posedge clk) begin
    bit    popped;
    bit    have;
    word_t w;
    if (rst) begin
      mq.delete();
      pend.delete();
      m_s1v = 0;
      m_s1f = 0;
      m_ovf = 0;
    end else begin
      popped = (mq.size() != 0) && out_ready;
      have   = 0;
      if (m_s1v) pend.push_back(m_s1p);
      if (pend.size() == 4 || (m_s1f && pend.size() != 0)) begin
        w.d = 0;
        for (int i = 0; i < pend.size(); i++) w.d = w.d | (32'(pend[i]) << (8 * i));
        w.k = 4'((1 << pend.size()) - 1);
        w.l = m_s1f;
        pend.delete();
        have = 1;
      end
      if (popped) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else m_ovf = 1;
      end
      m_s1v = in_valid;
      m_s1p = quant(gray_in);
      m_s1f = flush;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("cyc_data", out_data, mq[0].d);
        chk("cyc_keep", out_keep, mq[0].k);
        chk("cyc_last", out_last, mq[0].l);
      end else begin
        chk("cyc_data_idle", out_data, 0);
        chk("cyc_keep_idle", out_keep, 0);
        chk("cyc_last_idle", out_last, 0);
      end
      chk("cyc_overflow", overflow, m_ovf);
    end
  end

  task automatic pix(input logic [31:0] g, input logic f);
    in_valid = 1'b1;
    gray_in  = g;
    flush    = f;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic expect_word(input string name, input logic [31:0] d, input logic [3:0] k,
                             input logic l, output int waited);
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: out_valid=0, required 1", name);
    end else begin
      chk({name, "_data"}, out_data, d);
      chk({name, "_keep"}, out_keep, k);
      chk({name, "_last"}, out_last, l);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  function automatic logic [31:0] seq_word(input int first);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(first + i);
    return d;
  endfunction

  initial begin
    int w;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    do_reset();

    out_ready = 1'b1;
    pix(32'h0000_7FFF, 0);
    pix(32'h0000_8000, 0);
    pix(32'h00FF_7FFF, 0);
    pix(32'h0100_0000, 0);
    expect_word("round", 32'hFFFF_0100, 4'hF, 1'b0, w);

    pix(32'hFFFF_FFFF, 0);
    pix(32'h0000_0000, 0);
    pix(32'h0001_0000, 0);
    pix(32'h0002_8000, 0);
    expect_word("round2", 32'h0301_00FF, 4'hF, 1'b0, w);

    for (int i = 0; i < 4; i++) pix(32'(32'h10 + i) << 16, 0);
    expect_word("lat", 32'h1312_1110, 4'hF, 1'b0, w);
    chk("lat_cycles", w, 1);
    chk("lat_single", out_valid, 0);

    pix(32'h00AA_0000, 0);
    pix(32'h00BB_0000, 0);
    pix(32'h00CC_0000, 1);
    expect_word("pflush", 32'h00CC_BBAA, 4'h7, 1'b1, w);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (4) @(negedge clk);
    chk("lone_flush", out_valid, 0);

    for (int i = 1; i <= 4; i++) pix(32'(i) << 16, (i == 4));
    expect_word("fullflush", 32'h0403_0201, 4'hF, 1'b1, w);

    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) pix(32'(i) << 16, 0);
    chk("ovf_before", overflow, 0);
    @(negedge clk);
    chk("ovf_after", overflow, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_word("drain", seq_word(4 * i + 1), 4'hF, 1'b0, w);
    chk("drain_empty", out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) pix(32'(i) << 16, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pp_ovf", overflow, 0);
    @(negedge clk);
    chk("pp_ovf2", overflow, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) expect_word("pp_drain", seq_word(4 * i + 1), 4'hF, 1'b0, w);
    chk("pp_empty", out_valid, 0);

    for (int i = 0; i < 3; i++) pix(32'h0050_0000, 0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) pix(32'(32'h60 + i) << 16, 0);
    expect_word("rstmid", 32'h6362_6160, 4'hF, 1'b0, w);
    repeat (3) @(negedge clk);
    chk("rstmid_one", out_valid, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
